// File: rtl/imem_uart_loader_if.sv
// Byte stream in from the UART receiver and instruction-memory write port out.
// Signal names follow the loader's point of view (i_ = into loader, o_ = out of loader).
interface imem_uart_loader_if;
  logic        i_byte_valid;
  logic [7:0]  i_byte;
  logic        o_imem_we;
  logic [31:0] o_imem_addr;
  logic [31:0] o_imem_wdata;

  modport master (
    input  i_byte_valid,
    input  i_byte,
    output o_imem_we,
    output o_imem_addr,
    output o_imem_wdata
  );

  modport slave (
    output i_byte_valid,
    output i_byte,
    input  o_imem_we,
    input  o_imem_addr,
    input  o_imem_wdata
  );
endinterface

// File: rtl/imem_uart_loader.sv
// Loads a framed UART byte stream into instruction memory as big-endian words,
// holding the CPU off until a frame passes its checksum.
module imem_uart_loader #(
  parameter int unsigned MEM_SIZE       = 512,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                i_clk,
  input  logic                i_rst,
  imem_uart_loader_if.master  io_bus,
  output logic                o_cpu_hold,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_error,
  output logic [9:0]          o_words_loaded
);

  localparam int unsigned WIDX_W = (MEM_SIZE > 2) ? $clog2(MEM_SIZE) : 1;
  localparam int unsigned TO_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              r_state,   w_state_nxt;
  logic [7:0]          r_len_hi,  w_len_hi_nxt;
  logic [15:0]         r_len,     w_len_nxt;
  logic [7:0]          r_chk,     w_chk_nxt;
  logic [31:0]         r_asm,     w_asm_nxt;
  logic [1:0]          r_bidx,    w_bidx_nxt;
  logic [WIDX_W-1:0]   r_widx,    w_widx_nxt;
  logic [TO_W-1:0]     r_to,      w_to_nxt;
  logic                r_we,      w_we_nxt;
  logic [31:0]         r_addr,    w_addr_nxt;
  logic [31:0]         r_wdata,   w_wdata_nxt;
  logic                r_hold,    w_hold_nxt;
  logic                r_busy,    w_busy_nxt;
  logic                r_done,    w_done_nxt;
  logic                r_error,   w_error_nxt;
  logic [9:0]          r_words,   w_words_nxt;

  logic                w_valid;
  logic [7:0]          w_byte;
  logic [15:0]         w_len;
  logic                w_in_frame;
  logic                w_expire;
  logic                w_last_word;
  logic                w_fail;

  assign w_valid     = io_bus.i_byte_valid;
  assign w_byte      = io_bus.i_byte;
  assign w_len       = {r_len_hi, w_byte};
  assign w_in_frame  = (r_state == S_LEN_HI) || (r_state == S_LEN_LO) ||
                       (r_state == S_DATA)   || (r_state == S_CHECK);
  // An arriving byte always beats an expiring counter.
  assign w_expire    = w_in_frame && !w_valid && (r_to == TO_MAX);
  assign w_last_word = (16'(r_widx) == (r_len - 16'd1));

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_len_hi_nxt = r_len_hi;
    w_len_nxt    = r_len;
    w_chk_nxt    = r_chk;
    w_asm_nxt    = r_asm;
    w_bidx_nxt   = r_bidx;
    w_widx_nxt   = r_widx;
    w_to_nxt     = (w_in_frame && !w_valid) ? (r_to + TO_W'(1)) : '0;
    w_we_nxt     = 1'b0;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_hold_nxt   = r_hold;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_error_nxt  = r_error;
    w_words_nxt  = r_words;
    w_fail       = w_expire;

    case (r_state)
      S_IDLE: begin
        if (w_valid && (w_byte == SYNC_BYTE)) begin
          w_state_nxt = S_LEN_HI;
          w_error_nxt = 1'b0;
          w_chk_nxt   = 8'h00;
          w_words_nxt = 10'd0;
          w_busy_nxt  = 1'b1;
          w_hold_nxt  = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (w_valid) begin
          w_len_hi_nxt = w_byte;
          w_chk_nxt    = r_chk ^ w_byte;
          w_state_nxt  = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_valid) begin
          w_len_nxt = w_len;
          w_chk_nxt = r_chk ^ w_byte;
          if ((w_len == 16'd0) || (w_len > 16'(MEM_SIZE))) begin
            w_fail = 1'b1;
          end else begin
            w_state_nxt = S_DATA;
            w_bidx_nxt  = 2'd0;
            w_widx_nxt  = '0;
          end
        end
      end
      S_DATA: begin
        if (w_valid) begin
          w_chk_nxt  = r_chk ^ w_byte;
          w_asm_nxt  = {r_asm[23:0], w_byte};
          w_bidx_nxt = r_bidx + 2'd1;
          if (r_bidx == 2'd3) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = 32'({r_widx, 2'b00});
            w_wdata_nxt = {r_asm[23:0], w_byte};
            w_widx_nxt  = r_widx + WIDX_W'(1);
            w_words_nxt = r_words + 10'd1;
            if (w_last_word) begin
              w_state_nxt = S_CHECK;
            end
          end
        end
      end
      S_CHECK: begin
        if (w_valid) begin
          if (w_byte == r_chk) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_hold_nxt  = 1'b0;
          end else begin
            w_fail = 1'b1;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERROR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // CPU hold is deliberately left set so a corrupted image never runs.
    if (w_fail) begin
      w_state_nxt = S_ERROR;
      w_error_nxt = 1'b1;
      w_busy_nxt  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_len_hi <= 8'h00;
      r_len    <= 16'h0000;
      r_chk    <= 8'h00;
      r_asm    <= 32'h0;
      r_bidx   <= 2'd0;
      r_widx   <= '0;
      r_to     <= '0;
      r_we     <= 1'b0;
      r_addr   <= 32'h0;
      r_wdata  <= 32'h0;
      r_hold   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_words  <= 10'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_len_hi <= w_len_hi_nxt;
      r_len    <= w_len_nxt;
      r_chk    <= w_chk_nxt;
      r_asm    <= w_asm_nxt;
      r_bidx   <= w_bidx_nxt;
      r_widx   <= w_widx_nxt;
      r_to     <= w_to_nxt;
      r_we     <= w_we_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_hold   <= w_hold_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
      r_words  <= w_words_nxt;
    end
  end

  assign io_bus.o_imem_we    = r_we;
  assign io_bus.o_imem_addr  = r_addr;
  assign io_bus.o_imem_wdata = r_wdata;
  assign o_cpu_hold          = r_hold;
  assign o_busy              = r_busy;
  assign o_done              = r_done;
  assign o_error             = r_error;
  assign o_words_loaded      = r_words;

endmodule
